// File: rtl/gba_cart_pkg.sv
// Shared definitions for the GBA cartridge bus initiator: request opcodes,
// controller states and default strobe timing.
// SRAM states exist only when GBA_CART_MASTER_SRAM_EN is defined.
package gba_cart_pkg;

   // Default phase lengths in clock cycles
   localparam int unsigned ADDR_SETUP_DEF = 2;
   localparam int unsigned RD_LOW_DEF     = 4;
   localparam int unsigned RD_HIGH_DEF    = 2;

   // Width of the phase timer load value
   localparam int unsigned TMR_W = 16;

   typedef enum logic [1:0] {
      OP_ROM_RD  = 2'd0,
      OP_SRAM_RD = 2'd1,
      OP_SRAM_WR = 2'd2,
      OP_RSVD    = 2'd3
   } op_e;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_R_ADDR  = 4'd1,
      ST_R_LATCH = 4'd2,
      ST_R_RDLO  = 4'd3,
      ST_R_RDHI  = 4'd4,
`ifdef GBA_CART_MASTER_SRAM_EN
      ST_S_ADDR  = 4'd6,
      ST_S_STRB  = 4'd7,
      ST_S_END   = 4'd8,
`endif
      ST_R_END   = 4'd5
   } state_e;

endpackage

// File: rtl/gba_cart_phase_timer.sv
// Loadable down-counter timing one bus phase. Loading N starts a phase of
// N cycles; o_done is high for exactly the last cycle of that phase.
module gba_cart_phase_timer
   import gba_cart_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_cycles,
   output logic             o_done
);

   logic [TMR_W-1:0] r_cnt;
   logic             r_run;

   assign o_done = r_run && (r_cnt == '0);

   // Count the loaded phase down to zero, then go idle until reloaded
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_run <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_cycles - 1'b1;
         r_run <= 1'b1;
      end else if (o_done) begin
         r_run <= 1'b0;
      end else if (r_run) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/gba_cart_master.sv
// GBA cartridge bus initiator: turns host requests into CSn/CS2n/RDn/WRn
// sequences on the multiplexed AD/AH lines (ROM bursts, SRAM byte access).
// Build option: GBA_CART_MASTER_SRAM_EN enables SRAM read/write; without it
// SRAM requests are accepted and silently dropped.
module gba_cart_master
   import gba_cart_pkg::*;
#(
   parameter int unsigned ADDR_SETUP = ADDR_SETUP_DEF,
   parameter int unsigned RD_LOW     = RD_LOW_DEF,
   parameter int unsigned RD_HIGH    = RD_HIGH_DEF
) (
   input  logic        IwClk,
   input  logic        IwRstn,
   input  logic        IwReqValid,
   output logic        ObReqReady,
   input  logic [1:0]  IbReqOp,
   input  logic [23:0] IbReqAddr,
   input  logic [15:0] IbReqLen,
   input  logic [7:0]  IbReqWData,
   output logic        ObRspValid,
   input  logic        IwRspReady,
   output logic [15:0] ObRspData,
   output logic        ObRspLast,
   output logic        OwCartCSn,
   output logic        OwCartCS2n,
   output logic        OwCartRDn,
   output logic        OwCartWRn,
   inout  wire  [15:0] BbCartALD,
   inout  wire  [7:0]  BbCartAH
);

   localparam logic [TMR_W-1:0] C_SETUP = TMR_W'(ADDR_SETUP);
   localparam logic [TMR_W-1:0] C_LOW   = TMR_W'(RD_LOW);
   localparam logic [TMR_W-1:0] C_HIGH  = TMR_W'(RD_HIGH);
   localparam logic [TMR_W-1:0] C_ONE   = TMR_W'(1);

   state_e            r_state;
   state_e            w_next;
   logic [23:0]       r_addr;
   logic [15:0]       r_cnt;
   logic [7:0]        r_ah;
   logic [15:0]       r_data;
   logic              r_last;
   logic              r_rsp_vld;
   logic              r_rsp_last;
   logic              r_hi_done;
   logic              w_accept;
   logic              w_done;
   logic              w_tmr_load;
   logic [TMR_W-1:0]  w_tmr_cycles;
   logic              w_rd_end;
   logic              w_csn;
   logic              w_cs2n;
   logic              w_rdn;
   logic              w_wrn;
   logic              w_ald_oe;
   logic [15:0]       w_ald_o;
   logic              w_ah_oe;
   logic [7:0]        w_ah_o;

`ifdef GBA_CART_MASTER_SRAM_EN
   op_e               r_op;
   logic [7:0]        r_wdata;
   logic              w_sram_rd_end;
`else
   logic              w_unused_sram;
   assign w_unused_sram = ^{IbReqWData, BbCartAH};
`endif

   assign ObReqReady = (r_state == ST_IDLE);
   assign w_accept   = IwReqValid && ObReqReady;
   assign w_rd_end   = (r_state == ST_R_RDLO) && w_done;
   assign w_tmr_load = (w_next != r_state);

   gba_cart_phase_timer u_timer (
      .i_clk    (IwClk),
      .i_rst_n  (IwRstn),
      .i_load   (w_tmr_load),
      .i_cycles (w_tmr_cycles),
      .o_done   (w_done)
   );

   // State register
   always_ff @(posedge IwClk or negedge IwRstn) begin
      if (!IwRstn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   // Next state; a ROM burst breaks into a fresh access when A[15:0] wraps
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (IwReqValid) begin
               if (IbReqOp == OP_ROM_RD) w_next = ST_R_ADDR;
`ifdef GBA_CART_MASTER_SRAM_EN
               else if ((IbReqOp == OP_SRAM_RD) || (IbReqOp == OP_SRAM_WR)) w_next = ST_S_ADDR;
`endif
            end
         end
         ST_R_ADDR:  if (w_done) w_next = ST_R_LATCH;
         ST_R_LATCH: if (w_done) w_next = ST_R_RDLO;
         ST_R_RDLO:  if (w_done) w_next = ST_R_RDHI;
         ST_R_RDHI: begin
            if ((w_done || r_hi_done) && (!r_rsp_vld || IwRspReady)) begin
               if (r_last || (r_addr[15:0] == 16'h0000)) w_next = ST_R_END;
               else                                       w_next = ST_R_RDLO;
            end
         end
         ST_R_END: begin
            if (w_done) w_next = r_last ? ST_IDLE : ST_R_ADDR;
         end
`ifdef GBA_CART_MASTER_SRAM_EN
         ST_S_ADDR: if (w_done) w_next = ST_S_STRB;
         ST_S_STRB: if (w_done) w_next = ST_S_END;
         ST_S_END:  if (!r_rsp_vld || IwRspReady) w_next = ST_IDLE;
`endif
         default:   w_next = ST_IDLE;
      endcase
   end

   // Phase length loaded into the timer on every state change
   always_comb begin
      w_tmr_cycles = C_ONE;
      case (w_next)
         ST_R_ADDR: w_tmr_cycles = C_SETUP;
         ST_R_RDLO: w_tmr_cycles = C_LOW;
         ST_R_RDHI: w_tmr_cycles = C_HIGH;
`ifdef GBA_CART_MASTER_SRAM_EN
         ST_S_ADDR: w_tmr_cycles = C_SETUP;
         ST_S_STRB: w_tmr_cycles = C_LOW;
`endif
         default:   w_tmr_cycles = C_ONE;
      endcase
   end

   // Remember that RD_HIGH has elapsed while a response is still pending
   always_ff @(posedge IwClk or negedge IwRstn) begin
      if (!IwRstn)                                 r_hi_done <= 1'b0;
      else if (w_tmr_load)                         r_hi_done <= 1'b0;
      else if ((r_state == ST_R_RDHI) && w_done)   r_hi_done <= 1'b1;
   end

   // Latch the request; at each RDn rise capture data and step address/count
   always_ff @(posedge IwClk or negedge IwRstn) begin
      if (!IwRstn) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_ah   <= '0;
         r_data <= '0;
         r_last <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr <= IbReqAddr;
            r_cnt  <= IbReqLen;
         end
         if (r_state == ST_R_ADDR) r_ah <= r_addr[23:16];
         if (w_rd_end) begin
            r_data <= BbCartALD;
            r_last <= (r_cnt == 16'd0);
            r_addr <= r_addr + 24'd1;
            if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
         end
`ifdef GBA_CART_MASTER_SRAM_EN
         if (w_sram_rd_end) r_data <= {8'h00, BbCartAH};
`endif
      end
   end

`ifdef GBA_CART_MASTER_SRAM_EN
   assign w_sram_rd_end = (r_state == ST_S_STRB) && w_done && (r_op == OP_SRAM_RD);

   // SRAM operation and write byte, held for the whole access
   always_ff @(posedge IwClk or negedge IwRstn) begin
      if (!IwRstn) begin
         r_op    <= OP_ROM_RD;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_op    <= op_e'(IbReqOp);
         r_wdata <= IbReqWData;
      end
   end
`endif

   // Response handshake: raised with RDn, dropped when the host takes it
   always_ff @(posedge IwClk or negedge IwRstn) begin
      if (!IwRstn) begin
         r_rsp_vld  <= 1'b0;
         r_rsp_last <= 1'b0;
      end else begin
         if (r_rsp_vld && IwRspReady) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_last <= 1'b0;
         end
         if (w_rd_end) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_last <= (r_cnt == 16'd0);
         end
`ifdef GBA_CART_MASTER_SRAM_EN
         if (w_sram_rd_end) begin
            r_rsp_vld  <= 1'b1;
            r_rsp_last <= 1'b1;
         end
`endif
      end
   end

   // Pin levels decoded from state; ALD is released whenever the ROM drives it
   always_comb begin
      w_csn    = 1'b1;
      w_cs2n   = 1'b1;
      w_rdn    = 1'b1;
      w_wrn    = 1'b1;
      w_ald_oe = 1'b0;
      w_ald_o  = r_addr[15:0];
      w_ah_oe  = 1'b0;
      w_ah_o   = r_addr[23:16];
      case (r_state)
         ST_R_ADDR: begin
            w_ald_oe = 1'b1;
            w_ah_oe  = 1'b1;
         end
         ST_R_LATCH: begin
            w_csn    = 1'b0;
            w_ald_oe = 1'b1;
            w_ah_oe  = 1'b1;
            w_ah_o   = r_ah;
         end
         ST_R_RDLO: begin
            w_csn   = 1'b0;
            w_rdn   = 1'b0;
            w_ah_oe = 1'b1;
            w_ah_o  = r_ah;
         end
         ST_R_RDHI: begin
            w_csn   = 1'b0;
            w_ah_oe = 1'b1;
            w_ah_o  = r_ah;
         end
`ifdef GBA_CART_MASTER_SRAM_EN
         // SRAM returns data on AH only, so the address stays on ALD
         ST_S_ADDR: begin
            w_cs2n   = 1'b0;
            w_ald_oe = 1'b1;
            w_ah_oe  = (r_op == OP_SRAM_WR);
            w_ah_o   = r_wdata;
         end
         ST_S_STRB: begin
            w_cs2n   = 1'b0;
            w_ald_oe = 1'b1;
            w_ah_o   = r_wdata;
            if (r_op == OP_SRAM_WR) begin
               w_wrn   = 1'b0;
               w_ah_oe = 1'b1;
            end else begin
               w_rdn   = 1'b0;
            end
         end
`endif
         default: ;
      endcase
   end

   assign OwCartCSn  = w_csn;
`ifdef GBA_CART_MASTER_SRAM_EN
   assign OwCartCS2n = w_cs2n;
`else
   assign OwCartCS2n = 1'b1;
`endif
   assign OwCartRDn  = w_rdn;
   assign OwCartWRn  = w_wrn;
   assign BbCartALD  = w_ald_oe ? w_ald_o : 16'hzzzz;
   assign BbCartAH   = w_ah_oe  ? w_ah_o  : 8'hzz;
   assign ObRspValid = r_rsp_vld;
   assign ObRspData  = r_data;
   assign ObRspLast  = r_rsp_last;

endmodule

// File: tb/tb_gba_cart_master.sv
// Directed bench for gba_cart_master with a behavioural cartridge on the bus.
// ROM word at {hi,lo} = lo ^ 16'h5A00 ^ {8'h00,hi}; released lines pull high.
`timescale 1ns/1ps
module tb_gba_cart_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [23:0] req_addr = 24'd0;
   logic [15:0] req_len = 16'd0;
   logic [7:0]  req_wdata = 8'd0;
   logic        rsp_ready = 1'b1;
   wire         req_ready;
   wire         rsp_valid;
   wire  [15:0] rsp_data;
   wire         rsp_last;
   wire         cs_n, cs2_n, rd_n, wr_n;
   wire  [15:0] ald;
   wire  [7:0]  ah;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pullup (ald);
   pullup (ah);

   gba_cart_master dut (
      .IwClk      (clk),
      .IwRstn     (rst_n),
      .IwReqValid (req_valid),
      .ObReqReady (req_ready),
      .IbReqOp    (req_op),
      .IbReqAddr  (req_addr),
      .IbReqLen   (req_len),
      .IbReqWData (req_wdata),
      .ObRspValid (rsp_valid),
      .IwRspReady (rsp_ready),
      .ObRspData  (rsp_data),
      .ObRspLast  (rsp_last),
      .OwCartCSn  (cs_n),
      .OwCartCS2n (cs2_n),
      .OwCartRDn  (rd_n),
      .OwCartWRn  (wr_n),
      .BbCartALD  (ald),
      .BbCartAH   (ah)
   );

   // Cartridge ROM: latch A[15:0] on CSn fall, auto-increment on RDn rise
   logic [15:0] cart_lo = 16'd0;
   function automatic logic [15:0] rom_word(input logic [7:0] hi, input logic [15:0] lo);
      return lo ^ 16'h5A00 ^ {8'h00, hi};
   endfunction
   always @(negedge cs_n) cart_lo = ald;
   always @(posedge rd_n) if (!cs_n) cart_lo = cart_lo + 16'd1;
   assign ald = (!cs_n && !rd_n) ? rom_word(ah, cart_lo) : 16'hzzzz;

`ifdef GBA_CART_MASTER_SRAM_EN
   logic [7:0] sram [0:255];
   always @(negedge clk) if (!cs2_n && !wr_n) sram[ald[7:0]] <= ah;
   assign ah = (!cs2_n && !rd_n) ? sram[ald[7:0]] : 8'hzz;
`endif

   // Burst monitor results
   logic [15:0] got_data [16];
   logic        got_last [16];
   int          got_cyc  [16];
   int          got_n;
   logic [15:0] latch_ald [4];
   logic [7:0]  latch_ah  [4];
   int          n_latch;
   int          csn_rise;
   int          stall_bad;
   logic [15:0] stall_word;
   bit          coll_timeout;

   task automatic send_req(input logic [1:0] op, input logic [23:0] addr,
                           input logic [15:0] len, input logic [7:0] wd);
      req_op = op; req_addr = addr; req_len = len; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Follow one request to IDLE, recording responses, latches and CSn rises
   task automatic collect(input int stall_idx, input int stall_len);
      int   cyc;
      int   stall_left;
      logic prev_csn;
      cyc = 0; stall_left = stall_len; prev_csn = cs_n;
      got_n = 0; n_latch = 0; csn_rise = 0; stall_bad = 0; stall_word = 16'h0;
      while (!req_ready && cyc < 400) begin
         if (prev_csn && !cs_n && n_latch < 4) begin
            latch_ald[n_latch] = ald;
            latch_ah[n_latch]  = ah;
            n_latch++;
         end
         if (!prev_csn && cs_n) csn_rise++;
         prev_csn = cs_n;
         if (rsp_valid) begin
            if (got_n == stall_idx && stall_left > 0) begin
               if (stall_left == stall_len) stall_word = rsp_data;
               if (rd_n !== 1'b1 || cs_n !== 1'b0 || rsp_data !== stall_word) stall_bad++;
               rsp_ready = 1'b0;
               stall_left--;
            end else begin
               rsp_ready = 1'b1;
               if (got_n < 16) begin
                  got_data[got_n] = rsp_data;
                  got_last[got_n] = rsp_last;
                  got_cyc[got_n]  = cyc;
               end
               got_n++;
            end
         end else begin
            rsp_ready = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b1;
      coll_timeout = !req_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cs_n, cs2_n, rd_n, wr_n} !== 4'b1111) begin
         failures++; $display("FAIL reset_strobes got=%b want=1111", {cs_n, cs2_n, rd_n, wr_n});
      end
      checks++;
      if ({req_ready, rsp_valid, rsp_last} !== 3'b100) begin
         failures++; $display("FAIL reset_handshake got=%b want=100", {req_ready, rsp_valid, rsp_last});
      end
      checks++;
      if (rsp_data !== 16'h0000) begin
         failures++; $display("FAIL reset_rsp_data got=%h want=0000", rsp_data);
      end
      checks++;
      if ({ald, ah} !== 24'hFFFFFF) begin
         failures++; $display("FAIL reset_bus_released got=%h want=ffffff", {ald, ah});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready_after got=%b want=1", req_ready);
      end
   endtask

   task automatic test_rom_single();
      int cyc;
      send_req(2'd0, 24'h000100, 16'd0, 8'h00);
      checks++;
      if ({cs_n, ald, ah} !== {1'b1, 16'h0100, 8'h00}) begin
         failures++; $display("FAIL single_addr_phase got=%h want=%h", {cs_n, ald, ah}, {1'b1, 16'h0100, 8'h00});
      end
      cyc = 0;
      while (!rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 7) begin
         failures++; $display("FAIL single_rsp_latency got=%0d want=7", cyc);
      end
      checks++;
      if ({rd_n, cs_n} !== 2'b10) begin
         failures++; $display("FAIL single_rsp_strobes got=%b want=10", {rd_n, cs_n});
      end
      checks++;
      if (rsp_data !== 16'h5B00) begin
         failures++; $display("FAIL single_rsp_data got=%h want=5b00", rsp_data);
      end
      checks++;
      if (rsp_last !== 1'b1) begin
         failures++; $display("FAIL single_rsp_last got=%b want=1", rsp_last);
      end
      @(negedge clk); cyc++;
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++; $display("FAIL single_rsp_dropped got=%b want=0", rsp_valid);
      end
      while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc !== 10) begin
         failures++; $display("FAIL single_idle_latency got=%0d want=10", cyc);
      end
   endtask

   task automatic test_rom_burst_wrap();
      logic [15:0] exp_d [4];
      exp_d[0] = 16'hA5FE; exp_d[1] = 16'hA5FF; exp_d[2] = 16'h5A01; exp_d[3] = 16'h5A00;
      send_req(2'd0, 24'h00FFFE, 16'd3, 8'h00);
      collect(-1, 0);
      checks++;
      if (coll_timeout || got_n !== 4) begin
         failures++; $display("FAIL wrap_count got=%0d want=4 timeout=%0d", got_n, coll_timeout);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
            failures++; $display("FAIL wrap_word%0d got=%h/%b want=%h/%b", i, got_data[i], got_last[i], exp_d[i], (i == 3));
         end
      end
      checks++;
      if (n_latch !== 2 || csn_rise !== 2) begin
         failures++; $display("FAIL wrap_cs_pulses got=latch%0d/rise%0d want=latch2/rise2", n_latch, csn_rise);
      end
      checks++;
      if ({latch_ah[1], latch_ald[1]} !== 24'h010000) begin
         failures++; $display("FAIL wrap_relatch_addr got=%h want=010000", {latch_ah[1], latch_ald[1]});
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] !== 6) begin
         failures++; $display("FAIL wrap_throughput got=%0d want=6", got_cyc[1] - got_cyc[0]);
      end
   endtask

   task automatic test_backpressure();
      send_req(2'd0, 24'h000200, 16'd7, 8'h00);
      collect(2, 10);
      checks++;
      if (coll_timeout || got_n !== 8) begin
         failures++; $display("FAIL bp_count got=%0d want=8 timeout=%0d", got_n, coll_timeout);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got_data[i] !== 16'h5800 + 16'(i) || got_last[i] !== (i == 7)) begin
            failures++; $display("FAIL bp_word%0d got=%h/%b want=%h/%b", i, got_data[i], got_last[i], 16'h5800 + 16'(i), (i == 7));
         end
      end
      checks++;
      if (stall_bad !== 0) begin
         failures++; $display("FAIL bp_stall_hold got=%0d want=0 bad cycles", stall_bad);
      end
      checks++;
      if (n_latch !== 1) begin
         failures++; $display("FAIL bp_single_latch got=%0d want=1", n_latch);
      end
   endtask

`ifdef GBA_CART_MASTER_SRAM_EN
   task automatic test_sram();
      int cyc;
      int wr_low;
      int ah_bad;
      int rsp_seen;
      cyc = 0; wr_low = 0; ah_bad = 0; rsp_seen = 0;
      send_req(2'd2, 24'h001234, 16'd0, 8'hA5);
      while (!req_ready && cyc < 50) begin
         if (!wr_n) begin
            wr_low++;
            if (ah !== 8'hA5 || cs2_n !== 1'b0) ah_bad++;
         end
         if (rsp_valid) rsp_seen++;
         @(negedge clk); cyc++;
      end
      checks++;
      if (wr_low !== 4 || ah_bad !== 0) begin
         failures++; $display("FAIL sram_wr_pulse got=low%0d/bad%0d want=low4/bad0", wr_low, ah_bad);
      end
      checks++;
      if (rsp_seen !== 0) begin
         failures++; $display("FAIL sram_wr_no_rsp got=%0d want=0", rsp_seen);
      end
      send_req(2'd1, 24'h001234, 16'd0, 8'h00);
      collect(-1, 0);
      checks++;
      if (coll_timeout || got_n !== 1 || got_data[0] !== 16'h00A5 || got_last[0] !== 1'b1) begin
         failures++; $display("FAIL sram_rd got=n%0d/%h/%b want=n1/00a5/1", got_n, got_data[0], got_last[0]);
      end
   endtask
`else
   task automatic test_drop();
      int act;
      act = 0;
      send_req(2'd2, 24'h001234, 16'd0, 8'hA5);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL drop_ready got=%b want=1", req_ready);
      end
      send_req(2'd3, 24'h000040, 16'd0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         if ({cs_n, cs2_n, rd_n, wr_n} !== 4'b1111 || rsp_valid !== 1'b0 || req_ready !== 1'b1) act++;
         @(negedge clk);
      end
      checks++;
      if (act !== 0) begin
         failures++; $display("FAIL drop_bus_quiet got=%0d want=0 active cycles", act);
      end
      send_req(2'd0, 24'h000005, 16'd0, 8'h00);
      collect(-1, 0);
      checks++;
      if (coll_timeout || got_n !== 1 || got_data[0] !== 16'h5A05) begin
         failures++; $display("FAIL drop_then_rom got=n%0d/%h want=n1/5a05", got_n, got_data[0]);
      end
   endtask
`endif

   task automatic test_reset_mid();
      int cyc;
      send_req(2'd0, 24'h000300, 16'd0, 8'h00);
      cyc = 0;
      while (rd_n !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
      checks++;
      if (rd_n !== 1'b0) begin
         failures++; $display("FAIL rstmid_reach_rdlo got=%b want=0", rd_n);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cs_n, cs2_n, rd_n, wr_n} !== 4'b1111) begin
         failures++; $display("FAIL rstmid_strobes got=%b want=1111", {cs_n, cs2_n, rd_n, wr_n});
      end
      checks++;
      if ({ald, ah} !== 24'hFFFFFF || rsp_valid !== 1'b0) begin
         failures++; $display("FAIL rstmid_release got=%h/%b want=ffffff/0", {ald, ah}, rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
         failures++; $display("FAIL rstmid_after got=%b want=10", {req_ready, rsp_valid});
      end
   endtask

   initial begin
      test_reset();
      test_rom_single();
      test_rom_burst_wrap();
      test_backpressure();
`ifdef GBA_CART_MASTER_SRAM_EN
      test_sram();
`else
      test_drop();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
